// File: rtl/load_align_queue_if.sv
// Load-return queue bus: issue side, in-order memory responses and the writeback handshake.
interface load_align_queue_if #(
   parameter int REG_W = 5
);
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_addr_lo;
   logic [2:0]       req_size;
   logic             req_sign_ext;
   logic [1:0]       req_left_right;
   logic [31:0]      req_rt_data;
   logic [REG_W-1:0] req_dest;
   logic             rsp_valid;
   logic [31:0]      rsp_data;
   logic             wb_valid;
   logic             wb_ready;
   logic [31:0]      wb_data;
   logic [REG_W-1:0] wb_dest;

   modport master (
      output flush, req_valid, req_addr_lo, req_size, req_sign_ext, req_left_right,
             req_rt_data, req_dest, rsp_valid, rsp_data, wb_ready,
      input  req_ready, wb_valid, wb_data, wb_dest
   );

   modport slave (
      input  flush, req_valid, req_addr_lo, req_size, req_sign_ext, req_left_right,
             req_rt_data, req_dest, rsp_valid, rsp_data, wb_ready,
      output req_ready, wb_valid, wb_data, wb_dest
   );
endinterface

// File: rtl/load_align_queue.sv
// In-order load-return queue: records load format info, captures memory data in order,
// aligns/extends/merges it and hands results to writeback; flushed loads become ghosts.
module load_align_queue #(
   parameter int DEPTH  = 4,
   parameter int REG_W  = 5,
   parameter int BYPASS = 1
) (
   input logic             clk,
   input logic             rst,
   load_align_queue_if.slave lq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [2:0]       size;
      logic             sign_ext;
      logic [1:0]       lr;
      logic [1:0]       lo;
      logic [31:0]      rt;
      logic [REG_W-1:0] dest;
   } fmt_t;

   fmt_t        info     [DEPTH];
   logic [31:0] data_mem [DEPTH];

   logic [PW-1:0] head, tail, rsp_idx;
   // Responses arrive in order, so entries holding data are always a prefix from head;
   // data_cnt stands in for the per-entry has_data flags.
   logic [CW-1:0] count, data_cnt, ghost_cnt, kill_sum, ghost_flush;
   logic [CW:0]   occ;
   logic          enq, rsp_hit, rsp_ghost, head_ready, bypass, pop;
   logic [31:0]   pop_data, fmt_out;

   function automatic logic [31:0] format_load(input fmt_t f, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(d >> {f.lo, 3'b000});
      h = f.lo[1] ? d[31:16] : d[15:0];
      r = '0;
      case (f.size)
         3'd0: r = {{24{f.sign_ext & b[7]}}, b};
         3'd1: r = {{16{f.sign_ext & h[15]}}, h};
         3'd2: begin
            case (f.lr)
               2'd0: r = d;
               2'd1: begin
                  case (f.lo)
                     2'd0:    r = {d[7:0],  f.rt[23:0]};
                     2'd1:    r = {d[15:0], f.rt[15:0]};
                     2'd2:    r = {d[23:0], f.rt[7:0]};
                     default: r = d;
                  endcase
               end
               2'd2: begin
                  case (f.lo)
                     2'd0:    r = d;
                     2'd1:    r = {f.rt[31:24], d[31:8]};
                     2'd2:    r = {f.rt[31:16], d[31:16]};
                     default: r = {f.rt[31:8],  d[31:24]};
                  endcase
               end
               default: r = '0;
            endcase
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   assign occ          = {1'b0, count} + {1'b0, ghost_cnt};
   assign lq.req_ready = !lq.flush && (occ < DEPTH_V);
   assign enq          = lq.req_valid && lq.req_ready;

   assign rsp_ghost  = lq.rsp_valid && (ghost_cnt != '0);
   assign rsp_hit    = lq.rsp_valid && (ghost_cnt == '0) && (data_cnt != count);
   assign rsp_idx    = head + data_cnt[PW-1:0];
   assign head_ready = (data_cnt != '0);
   assign bypass     = (BYPASS != 0) && rsp_hit && !head_ready;
   assign pop        = !lq.flush && (!lq.wb_valid || lq.wb_ready) && (head_ready || bypass);
   assign pop_data   = head_ready ? data_mem[head] : lq.rsp_data;
   assign fmt_out    = format_load(info[head], pop_data);

   // On flush every entry still waiting for data turns into a ghost; a response in the
   // same cycle retires one of them (or an older ghost).
   assign kill_sum    = ghost_cnt + (count - data_cnt);
   assign ghost_flush = (lq.rsp_valid && (kill_sum != '0)) ? kill_sum - CW'(1) : kill_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         data_cnt    <= '0;
         ghost_cnt   <= '0;
         lq.wb_valid <= 1'b0;
         lq.wb_data  <= '0;
         lq.wb_dest  <= '0;
      end else if (lq.flush) begin
         head        <= tail;
         count       <= '0;
         data_cnt    <= '0;
         ghost_cnt   <= ghost_flush;
         lq.wb_valid <= 1'b0;
      end else begin
         if (enq) tail <= tail + PW'(1);
         if (pop) head <= head + PW'(1);
         count     <= count + CW'(enq) - CW'(pop);
         data_cnt  <= data_cnt + CW'(rsp_hit) - CW'(pop);
         ghost_cnt <= ghost_cnt - CW'(rsp_ghost);
         if (pop) begin
            lq.wb_valid <= 1'b1;
            lq.wb_data  <= fmt_out;
            lq.wb_dest  <= info[head].dest;
         end else if (lq.wb_ready) begin
            lq.wb_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         info[tail] <= '{size: lq.req_size, sign_ext: lq.req_sign_ext, lr: lq.req_left_right,
                         lo: lq.req_addr_lo, rt: lq.req_rt_data, dest: lq.req_dest};
      end
      if (rsp_hit) data_mem[rsp_idx] <= lq.rsp_data;
   end
endmodule

// File: tb/tb_load_align_queue.sv
// Bench for load_align_queue: format vector table, fill/stall, flush ghosts, wrap-around
// with random stalls and reset mid-stall; results checked against an expected-result queue.
module tb_load_align_queue;
   localparam int DEPTH = 4;
   localparam int REG_W = 5;
   localparam int NV    = 19;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   load_align_queue_if #(.REG_W(REG_W)) lq ();

   load_align_queue #(.DEPTH(DEPTH), .REG_W(REG_W), .BYPASS(1)) dut (
      .clk (clk),
      .rst (rst),
      .lq  (lq)
   );

   typedef struct {
      logic [31:0]      data;
      logic [REG_W-1:0] dest;
   } exp_t;

   typedef struct {
      logic [2:0]  size;
      logic        sign;
      logic [1:0]  lr;
      logic [1:0]  lo;
      logic [31:0] rt;
      logic [31:0] rsp;
      logic [31:0] exp;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   vec_t        vecs [NV];
   logic [31:0] wdata [10];
   logic [31:0] fill_d [4];
   int          errors  = 0;
   int          checks  = 0;
   int          out_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && lq.wb_valid && lq.wb_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data 0x%08h dest %0d, expected no output at %0t",
                     lq.wb_data, lq.wb_dest, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_data", lq.wb_data, mon_e.data);
            chk("wb_dest", 32'(lq.wb_dest), 32'(mon_e.dest));
            out_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] size, input logic sign, input logic [1:0] lr,
                          input logic [1:0] lo, input logic [31:0] rt,
                          input logic [REG_W-1:0] dest);
      lq.req_valid      = 1'b1;
      lq.req_size       = size;
      lq.req_sign_ext   = sign;
      lq.req_left_right = lr;
      lq.req_addr_lo    = lo;
      lq.req_rt_data    = rt;
      lq.req_dest       = dest;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d results still pending after %0d cycles, required 0",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int issued, answered, cyc, start;

      vecs[0]  = '{3'd0, 1'b1, 2'd0, 2'd3, 32'h0,        32'h80FF1234, 32'hFFFFFF80};
      vecs[1]  = '{3'd0, 1'b0, 2'd0, 2'd3, 32'h0,        32'h80FF1234, 32'h00000080};
      vecs[2]  = '{3'd2, 1'b0, 2'd1, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD};
      vecs[3]  = '{3'd2, 1'b0, 2'd2, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122};
      vecs[4]  = '{3'd1, 1'b1, 2'd0, 2'd2, 32'h0,        32'h80010000, 32'hFFFF8001};
      vecs[5]  = '{3'd1, 1'b0, 2'd0, 2'd1, 32'h0,        32'h1234F00D, 32'h0000F00D};
      vecs[6]  = '{3'd1, 1'b1, 2'd0, 2'd0, 32'h0,        32'h1234F00D, 32'hFFFFF00D};
      vecs[7]  = '{3'd2, 1'b0, 2'd0, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h11223344};
      vecs[8]  = '{3'd2, 1'b0, 2'd1, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h44BBCCDD};
      vecs[9]  = '{3'd2, 1'b0, 2'd1, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'h11223344};
      vecs[10] = '{3'd2, 1'b0, 2'd2, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hAA112233};
      vecs[11] = '{3'd2, 1'b0, 2'd2, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11};
      vecs[12] = '{3'd2, 1'b0, 2'd2, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h11223344};
      vecs[13] = '{3'd2, 1'b0, 2'd3, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h00000000};
      vecs[14] = '{3'd3, 1'b1, 2'd0, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h00000000};
      vecs[15] = '{3'd0, 1'b1, 2'd0, 2'd1, 32'h0,        32'h11223344, 32'h00000033};
      vecs[16] = '{3'd0, 1'b1, 2'd0, 2'd2, 32'h0,        32'h00A50000, 32'hFFFFFFA5};
      vecs[17] = '{3'd2, 1'b0, 2'd1, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'h223344DD};
      vecs[18] = '{3'd1, 1'b1, 2'd0, 2'd3, 32'h0,        32'h7FFF8000, 32'h00007FFF};
      fill_d[0] = 32'hCAFE0001; fill_d[1] = 32'hBEEF0002;
      fill_d[2] = 32'h12345678; fill_d[3] = 32'h87654321;

      lq.flush = 1'b0; lq.req_valid = 1'b0; lq.req_addr_lo = '0; lq.req_size = '0;
      lq.req_sign_ext = 1'b0; lq.req_left_right = '0; lq.req_rt_data = '0; lq.req_dest = '0;
      lq.rsp_valid = 1'b0; lq.rsp_data = '0; lq.wb_ready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_wb_valid", 32'(lq.wb_valid), 32'd0);
      chk("reset_wb_data", lq.wb_data, 32'd0);
      chk("reset_wb_dest", 32'(lq.wb_dest), 32'd0);
      chk("reset_req_ready", 32'(lq.req_ready), 32'd1);

      // format table: request, response one cycle later, result the cycle after
      for (int i = 0; i < NV; i++) begin
         set_req(vecs[i].size, vecs[i].sign, vecs[i].lr, vecs[i].lo, vecs[i].rt, REG_W'(i + 1));
         exp_q.push_back(exp_t'{vecs[i].exp, REG_W'(i + 1)});
         tick();
         lq.req_valid = 1'b0;
         lq.rsp_valid = 1'b1;
         lq.rsp_data  = vecs[i].rsp;
         tick();
         lq.rsp_valid = 1'b0;
         chk("bypass_latency", 32'(lq.wb_valid), 32'd1);
         drain("vec_drain", 10);
      end

      // fill, then stall with all data present
      for (int k = 0; k < DEPTH; k++) begin
         set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(20 + k));
         exp_q.push_back(exp_t'{fill_d[k], REG_W'(20 + k)});
         tick();
      end
      lq.req_valid = 1'b0;
      chk("full_req_ready", 32'(lq.req_ready), 32'd0);
      lq.wb_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         lq.rsp_valid = 1'b1;
         lq.rsp_data  = fill_d[k];
         tick();
      end
      lq.rsp_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("stall_valid", 32'(lq.wb_valid), 32'd1);
         chk("stall_data", lq.wb_data, fill_d[0]);
         chk("stall_dest", 32'(lq.wb_dest), 32'd20);
         tick();
      end
      lq.wb_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         chk("burst_valid", 32'(lq.wb_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      drain("fill_drain", 5);

      // flush with 3 outstanding and a response in the flush cycle -> 2 ghosts
      for (int k = 0; k < 3; k++) begin
         set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(k));
         tick();
      end
      lq.flush     = 1'b1;
      lq.rsp_valid = 1'b1;
      lq.rsp_data  = 32'hDEAD0000;
      set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(31));
      #1;
      chk("flush_req_ready", 32'(lq.req_ready), 32'd0);
      tick();
      lq.flush = 1'b0; lq.rsp_valid = 1'b0; lq.req_valid = 1'b0;
      chk("flush_wb_valid", 32'(lq.wb_valid), 32'd0);
      set_req(3'd0, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(7));
      exp_q.push_back(exp_t'{32'h000000A1, REG_W'(7)});
      tick();
      set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(9));
      exp_q.push_back(exp_t'{32'h5555AAAA, REG_W'(9)});
      tick();
      lq.req_valid = 1'b0;
      chk("ghost_req_ready", 32'(lq.req_ready), 32'd0);
      lq.rsp_valid = 1'b1;
      lq.rsp_data = 32'hDEAD0001; tick();
      lq.rsp_data = 32'hDEAD0002; tick();
      lq.rsp_data = 32'h123456A1; tick();
      lq.rsp_data = 32'h5555AAAA; tick();
      lq.rsp_valid = 1'b0;
      drain("flush_drain", 10);

      // wrap-around with random writeback stalls
      issued = 0; answered = 0; cyc = 0; start = out_cnt;
      while ((answered < 10 || exp_q.size() != 0) && cyc < 400) begin
         lq.wb_ready  = 1'($urandom_range(0, 1));
         lq.req_valid = 1'b0;
         lq.rsp_valid = 1'b0;
         if (answered < issued) begin
            lq.rsp_valid = 1'b1;
            lq.rsp_data  = wdata[answered];
            answered++;
         end
         if (issued < 10 && lq.req_ready) begin
            wdata[issued] = $urandom;
            set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(issued + 8));
            exp_q.push_back(exp_t'{wdata[issued], REG_W'(issued + 8)});
            issued++;
         end
         tick();
         cyc++;
      end
      lq.req_valid = 1'b0; lq.rsp_valid = 1'b0; lq.wb_ready = 1'b1;
      chk("wrap_out_count", 32'(out_cnt - start), 32'd10);
      drain("wrap_drain", 5);

      // reset mid-stall with 2 entries and one ghost
      lq.wb_ready = 1'b0;
      set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(1));
      tick();
      lq.req_valid = 1'b0;
      lq.flush = 1'b1;
      tick();
      lq.flush = 1'b0;
      set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(2)); tick();
      set_req(3'd2, 1'b0, 2'd0, 2'd0, 32'h0, REG_W'(3)); tick();
      lq.req_valid = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_wb_valid", 32'(lq.wb_valid), 32'd0);
      chk("rst_req_ready", 32'(lq.req_ready), 32'd1);
      lq.wb_ready  = 1'b1;
      lq.rsp_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lq.rsp_data = 32'hBAD00000 + 32'(k);
         tick();
      end
      lq.rsp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stray_rsp_wb_valid", 32'(lq.wb_valid), 32'd0);
         tick();
      end
      for (int k = 0; k < DEPTH; k++) begin
         chk("post_rst_req_ready", 32'(lq.req_ready), 32'd1);
         set_req(3'd1, 1'b0, 2'd0, 2'd2, 32'h0, REG_W'(12 + k));
         exp_q.push_back(exp_t'{32'h00000000 + 32'(16'hC000 + 16'(k)), REG_W'(12 + k)});
         tick();
      end
      lq.req_valid = 1'b0;
      chk("post_rst_full", 32'(lq.req_ready), 32'd0);
      lq.rsp_valid = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         lq.rsp_data = {16'hC000 + 16'(k), 16'h1111};
         tick();
      end
      lq.rsp_valid = 1'b0;
      drain("post_rst_drain", 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/load_align_queue.md
Name: load_align_queue

Overview:
- In-order load-return queue between the memory stage and writeback.
- Records each issued load's format info (size, sign extension, LWL/LWR mode, rt merge value, destination register).
- Captures in-order memory responses and formats the returned word (byte/half extraction, sign/zero extension, LWL/LWR merge). Presents results to writeback through a valid/ready registered output.
- Supports pipeline flush: un-returned loads become ghosts, and their late responses are silently discarded.

Parameters:
DEPTH, 4, queue entries; power of two, >=2
REG_W, 5, destination register index width
BYPASS, 1, 1 = response for head entry may be formatted in its arrival cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  kill all queued and not-yet-output loads
req_valid  in  1  load issued this cycle
req_ready  out  1  queue can accept a request
req_addr_lo  in  2  effective address [1:0]
req_size  in  3  0 byte, 1 half, 2 word, others reserved
req_sign_ext  in  1  sign-extend byte/half
req_left_right  in  2  word loads: 0 plain, 1 LWL, 2 LWR
req_rt_data  in  32  current rt value for LWL/LWR merge
req_dest  in  REG_W  destination register
rsp_valid  in  1  memory read data returned; always accepted, in issue order
rsp_data  in  32  raw little-endian word
wb_valid  out  1  formatted result valid (registered)
wb_ready  in  1  writeback consumes result
wb_data  out  32  formatted load result
wb_dest  out  REG_W  destination of wb_data

Behaviour:
- Reset values: wb_valid=0, wb_data=0, wb_dest=0, queue empty, ghost_cnt=0, req_ready=1 on the cycle after rst deasserts. rst has priority over every input.
- Storage:
  - Circular buffer with head/tail pointers and count, each of width clog2(DEPTH)+1 as needed.
  - Per-entry fields: format info, rt_data, dest, has_data, data.
- Accounting:
  - ghost_cnt counts discarded outstanding responses; range 0..DEPTH.
  - req_ready = !flush && (count + ghost_cnt < DEPTH).
  - Enqueue on req_valid && req_ready.
- Response routing, in order:
  - If ghost_cnt>0: decrement ghost_cnt, drop the data.
  - Else: write the data to the oldest entry with has_data=0.
  - rsp_valid with no ghost and no waiting entry is a protocol error; the response is ignored.
- Output register:
  - Loads when (!wb_valid || wb_ready) and the head has data, or when BYPASS=1, head has no data and this cycle's response targets the head.
  - On load, pop the head.
  - Latency with BYPASS=1 and an idle output: rsp in cycle N gives wb_valid in N+1. With BYPASS=0 it is N+2.
- Stall: wb_valid && !wb_ready holds wb_data/wb_dest stable. Responses keep landing in entries.
- Formatting, using the little-endian byte lane k = addr_lo:
  - Byte: lane k; sign_ext replicates bit 8k+7, else zero-fill.
  - Half: addr_lo[1]=0 uses [15:0], =1 uses [31:16]; extended as for byte. addr_lo[0] is ignored.
  - Word, lr=0: data.
  - LWL, by k=0..3: {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
  - LWR, by k=0..3: d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
  - Word with lr=3, or reserved size: result 0.
- Flush (same-cycle priority: rst > flush > others):
  - Next wb_valid=0; all entries freed.
  - ghost_cnt_next = ghost_cnt + (entries with has_data=0) - rsp_valid. The response in the flush cycle therefore retires one old ghost or one killed entry.
  - req_valid in the flush cycle is not enqueued (req_ready=0).
  - wb_ready in the flush cycle is irrelevant.
- Simultaneous enqueue, response and pop in one cycle are all legal.
  - count_next = count + enq - pop.
  - Enqueue into a full queue is impossible by req_ready.
  - A response cannot target the entry being enqueued in the same cycle.
- Pointers wrap modulo DEPTH.

Test Plan:
1. Reset, then LB addr_lo=3 sign_ext=1, then rsp 0x80FF_1234 one cycle later, wb_ready=1 -> wb_valid in the cycle after rsp, wb_data=0xFFFF_FF80; LBU addr_lo=3 on the same data -> 0x0000_0080.
2. LWL addr_lo=1 rt=0xAABBCCDD, rsp 0x11223344 -> wb_data=0x3344CCDD; LWR addr_lo=2 same rt/rsp -> 0xAABB1122; LH addr_lo=2 sign_ext=1 rsp 0x8001_0000 -> 0xFFFF8001.
3. Fill: DEPTH=4 requests with no responses -> req_ready=0 after the 4th; hold wb_ready=0, return 4 responses -> all stored, first result held stable; release wb_ready -> 4 results in order with correct wb_dest, one per cycle.
4. Flush with 3 outstanding (0 returned) and rsp_valid=1 in the flush cycle -> ghost_cnt=2, wb_valid=0; next 2 responses dropped; a new load issued after the flush receives the 3rd post-flush response.
5. Wrap-around: 10 back-to-back load/response pairs at DEPTH=4 with random wb_ready stalls -> output order and dest match issue order, no loss or duplication.
6. Reset asserted mid-stall with 2 entries and ghost_cnt=1 -> the following cycle wb_valid=0, req_ready=1, and later responses are treated as protocol errors and ignored.
